// File: rtl/spi_mem_ctrl_pkg.sv
// Shared constants, FSM state type and byte-order helpers for the SPI SRAM controller.
package spi_mem_pkg;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD
  } state_t;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Number of data bits minus one for a given access size.
  function automatic logic [7:0] data_bits_m1(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 8'd7;
      SIZE_HALF: return 8'd15;
      default:   return 8'd31;
    endcase
  endfunction

  // The shift register receives the lowest-address byte first, so the last
  // received byte sits in sh[7:0]; reorder to little-endian and zero-extend.
  function automatic logic [31:0] rx_word(input logic [31:0] sh, input logic [1:0] size);
    case (size)
      SIZE_BYTE: return {24'h0, sh[7:0]};
      SIZE_HALF: return {16'h0, sh[7:0], sh[15:8]};
      default:   return byte_swap(sh);
    endcase
  endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Core-side memory port of the SPI SRAM controller.
// Optional access size port is present when SPI_MEM_SIZE_EN is defined.
interface spi_mem_ctrl_if #(
  parameter int ADDR_W = 24
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              busy;
  logic              done;
`ifdef SPI_MEM_SIZE_EN
  logic [1:0]        size;

  modport master (output mem_read, mem_write, addr, wdata, size,
                  input  rdata, busy, done);
  modport slave  (input  mem_read, mem_write, addr, wdata, size,
                  output rdata, busy, done);
`else
  modport master (output mem_read, mem_write, addr, wdata,
                  input  rdata, busy, done);
  modport slave  (input  mem_read, mem_write, addr, wdata,
                  output rdata, busy, done);
`endif
endinterface

// File: rtl/spi_mem_ctrl_sck_gen.sv
// SCK divider: CLK_DIV clk cycles per half-period, mode 0 (idles low while disabled).
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc        = en && (cnt == '0);
  assign rise_tick = tc && !sck;
  assign fall_tick = tc && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= LOAD;
      sck <= 1'b0;
    end else if (cnt == '0) begin
      cnt <= LOAD;
      sck <= ~sck;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// Load/store responder that runs each request as a 23LC-style SPI SRAM transaction.
// Build option SPI_MEM_SIZE_EN adds byte/half/word access sizes.
//
// state   | meaning
// IDLE    | waiting for mem_read/mem_write, request latched on acceptance
// CMD     | shifting the 8-bit command
// ADDR    | shifting ADDR_W address bits, MSB first
// DATA    | transferring data bytes, lowest address first
// HOLD    | chip deselected for CLK_DIV cycles before the next request
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_mem_ctrl_if.slave        bus,
  output logic                 spi_sck,
  output logic                 spi_cs_n,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int HCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t            state;
  logic              cs_n_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       rdata_q;
  logic              is_wr;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] addr_sh;
  logic [31:0]       sh;
  logic [7:0]        bit_cnt;
  logic [HCW-1:0]    hold_cnt;
  logic [1:0]        size_eff;
  logic [7:0]        cmd;
  logic              rise_tick;
  logic              fall_tick;

`ifdef SPI_MEM_SIZE_EN
  logic [1:0] size_q;
  assign size_eff = size_q;
`else
  assign size_eff = SIZE_WORD;
`endif

  assign cmd       = bus.mem_write ? CMD_WRITE : CMD_READ;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_mosi  = mosi_q;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (~cs_n_q),
    .sck       (spi_sck),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      is_wr    <= 1'b0;
      wdata_q  <= '0;
      addr_sh  <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
`ifdef SPI_MEM_SIZE_EN
      size_q   <= SIZE_WORD;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.mem_write || bus.mem_read) begin
            is_wr   <= bus.mem_write;
            addr_sh <= bus.addr;
            wdata_q <= bus.wdata;
`ifdef SPI_MEM_SIZE_EN
            size_q  <= bus.size;
`endif
            sh      <= {cmd, 24'h0};
            mosi_q  <= cmd[7];
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            bit_cnt <= 8'd7;
            state   <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (fall_tick) begin
            if (bit_cnt == 8'd0) begin
              mosi_q  <= addr_sh[ADDR_W-1];
              bit_cnt <= 8'(ADDR_W - 1);
              state   <= ST_ADDR;
            end else begin
              sh      <= sh << 1;
              mosi_q  <= sh[30];
              bit_cnt <= bit_cnt - 8'd1;
            end
          end
        end

        ST_ADDR: begin
          if (fall_tick) begin
            if (bit_cnt == 8'd0) begin
              bit_cnt <= data_bits_m1(size_eff);
              state   <= ST_DATA;
              if (is_wr) begin
                sh     <= byte_swap(wdata_q);
                mosi_q <= wdata_q[7];
              end else begin
                sh     <= '0;
                mosi_q <= 1'b0;
              end
            end else begin
              addr_sh <= addr_sh << 1;
              mosi_q  <= addr_sh[ADDR_W-2];
              bit_cnt <= bit_cnt - 8'd1;
            end
          end
        end

        ST_DATA: begin
          // Rise and fall ticks never coincide, so the register is either
          // sampling MISO (reads) or feeding MOSI (writes).
          if (rise_tick && !is_wr) begin
            sh <= {sh[30:0], spi_miso};
          end
          if (fall_tick) begin
            if (bit_cnt == 8'd0) begin
              cs_n_q   <= 1'b1;
              mosi_q   <= 1'b0;
              done_q   <= 1'b1;
              hold_cnt <= HCW'(CLK_DIV - 1);
              state    <= ST_HOLD;
              if (!is_wr) begin
                rdata_q <= rx_word(sh, size_eff);
              end
            end else begin
              bit_cnt <= bit_cnt - 8'd1;
              if (is_wr) begin
                sh     <= sh << 1;
                mosi_q <= sh[30];
              end
            end
          end
        end

        ST_HOLD: begin
          if (hold_cnt == '0) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - HCW'(1);
          end
        end

        default: begin
          state  <= ST_IDLE;
          cs_n_q <= 1'b1;
          busy_q <= 1'b0;
          mosi_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Scoreboard bench for spi_mem_ctrl with a behavioural SPI SRAM model on the pins.
module tb_spi_mem_ctrl;
  import spi_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spi_sck, spi_cs_n, spi_mosi;
  logic spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_mem_ctrl_if #(.ADDR_W(24)) bus ();

  spi_mem_ctrl #(.ADDR_W(24), .CLK_DIV(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .spi_sck  (spi_sck),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: captures MOSI on SCK rise, presents read data after SCK fall.
  logic [63:0] cap = '0;
  int          bitcnt = 0;
  logic [31:0] rd_stream = '0;

  always @(posedge spi_sck or negedge spi_cs_n) begin
    if (spi_sck) begin
      cap    = {cap[62:0], spi_mosi};
      bitcnt = bitcnt + 1;
    end else begin
      cap    = '0;
      bitcnt = 0;
    end
  end

  always @(negedge spi_sck or negedge spi_cs_n) begin
    if (bitcnt >= 32 && bitcnt < 64) spi_miso = rd_stream[63 - bitcnt];
    else                             spi_miso = 1'b0;
  end

  typedef struct {
    logic [63:0] mosi;
    int          nbits;
    logic [31:0] rdata;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic [63:0] mask;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no transaction (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          mask = (e.nbits >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << e.nbits) - 64'd1);
          chk("done_cycle",   64'(cyc),          64'(e.done_cyc));
          chk("cs_n_at_done", 64'(spi_cs_n),     64'd1);
          chk("bit_count",    64'(bitcnt),       64'(e.nbits));
          chk("mosi_stream",  cap & mask,        e.mosi);
          chk("rdata",        64'(bus.rdata),    64'(e.rdata));
          @(negedge clk);
          chk("busy_hold",    64'(bus.busy),     64'd1);
          @(negedge clk);
          chk("busy_fall",    64'(bus.busy),     64'd0);
        end
      end
    end
  end

  task automatic start_req(input logic rd, input logic wr, input logic [23:0] a,
                           input logic [31:0] wd, output int k);
    @(posedge clk); #1;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    k = cyc;
  endtask

  task automatic wait_busy(input logic lvl, input int limit, input string name);
    int n;
    n = 0;
    while (bus.busy !== lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy !== lvl) begin
      checks++;
      errors++;
      $display("FAIL %s: got busy=%b expected %b within %0d cycles", name, bus.busy, lvl, limit);
    end
  endtask

  initial begin : timeout
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k;
    int n;
    logic [31:0] last_rd;
    last_rd = 32'h0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
`ifdef SPI_MEM_SIZE_EN
    bus.size = SIZE_WORD;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n",  64'(spi_cs_n),  64'd1);
    chk("rst_sck",   64'(spi_sck),   64'd0);
    chk("rst_mosi",  64'(spi_mosi),  64'd0);
    chk("rst_busy",  64'(bus.busy),  64'd0);
    chk("rst_done",  64'(bus.done),  64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted at cycle 100 of a write aborts it.
    start_req(1'b0, 1'b1, 24'h000555, 32'h55AA55AA, k);
    wait_busy(1'b1, 10, "abort_start");
    while (cyc < k + 100) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    bus.mem_write = 1'b0;
    #1;
    chk("abort_cs_n", 64'(spi_cs_n), 64'd1);
    chk("abort_sck",  64'(spi_sck),  64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_mosi", 64'(spi_mosi), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    // Word read: model returns 0x78,0x56,0x34,0x12.
    rd_stream = 32'h78563412;
    start_req(1'b1, 1'b0, 24'h000100, 32'h0, k);
    last_rd = 32'h12345678;
    exp_q.push_back('{mosi: 64'h03000100_00000000, nbits: 64, rdata: last_rd, done_cyc: k + 257});
    wait_busy(1'b1, 10, "read_start");
    bus.mem_read = 1'b0;
    wait_busy(1'b0, 400, "read_end");

    // Word write.
    start_req(1'b0, 1'b1, 24'h001234, 32'hA1B2C3D4, k);
    exp_q.push_back('{mosi: 64'h02001234_D4C3B2A1, nbits: 64, rdata: last_rd, done_cyc: k + 257});
    wait_busy(1'b1, 10, "write_start");
    bus.mem_write = 1'b0;
    wait_busy(1'b0, 400, "write_end");

    // Both strobes: write wins; mid-transaction input changes are ignored.
    start_req(1'b1, 1'b1, 24'h00ABCD, 32'h11223344, k);
    exp_q.push_back('{mosi: 64'h0200ABCD_44332211, nbits: 64, rdata: last_rd, done_cyc: k + 257});
    while (cyc < k + 20) begin
      @(posedge clk); #1;
    end
    bus.addr  = 24'hFFFFFF;
    bus.wdata = 32'h0;
    while (cyc < k + 200) begin
      @(posedge clk); #1;
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    wait_busy(1'b0, 400, "both_end");

    // Back-to-back reads with mem_read held.
    rd_stream = 32'hEFBEADDE;
    start_req(1'b1, 1'b0, 24'h000200, 32'h0, k);
    last_rd = 32'hDEADBEEF;
    exp_q.push_back('{mosi: 64'h03000200_00000000, nbits: 64, rdata: last_rd, done_cyc: k + 257});
    exp_q.push_back('{mosi: 64'h03000200_00000000, nbits: 64, rdata: last_rd, done_cyc: k + 516});
    n = 0;
    while (bus.done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (spi_cs_n === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_cs_gap", 64'(n), 64'd3);
    bus.mem_read = 1'b0;
    wait_busy(1'b0, 400, "b2b_end");
    repeat (5) @(negedge clk);
    chk("b2b_no_third_cs", 64'(spi_cs_n), 64'd1);
    chk("b2b_no_third_busy", 64'(bus.busy), 64'd0);

`ifdef SPI_MEM_SIZE_EN
    // Byte read: N=40, done at cycle 161, upper bytes zero.
    bus.size  = SIZE_BYTE;
    rd_stream = 32'hF0000000;
    start_req(1'b1, 1'b0, 24'h000300, 32'h0, k);
    last_rd = 32'h000000F0;
    exp_q.push_back('{mosi: 64'h00000003_00030000, nbits: 40, rdata: last_rd, done_cyc: k + 161});
    wait_busy(1'b1, 10, "byte_start");
    bus.mem_read = 1'b0;
    wait_busy(1'b0, 400, "byte_end");
    bus.size = SIZE_WORD;
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
